// File: rtl/inv_cipher_round_unit_if.sv
// Beat interface of the AES inverse-cipher round unit.
// Valid-only handshake: a beat transfers on every rising edge where valid_in=1; there is no ready and no stall.
interface inv_cipher_round_unit_if;
  logic         valid_in;
  logic         last_round;
  logic [0:127] state;
  logic [0:127] key;
  logic [0:127] round_out;
  logic         valid_out;

  modport master (
    output valid_in, last_round, state, key,
    input  round_out, valid_out
  );

  modport slave (
    input  valid_in, last_round, state, key,
    output round_out, valid_out
  );
endinterface

// File: rtl/inv_cipher_round_unit.sv
// One registered AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
// Define INV_ROUND_TRACE_EN to print per-beat intermediates in simulation.
module inv_cipher_round_unit (
  input logic                   clk,
  input logic                   rst,
  inv_cipher_round_unit_if.slave bus
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column product for one output byte; coefficients 0e,0b,0d,09 built from x2/x4/x8.
  function automatic logic [7:0] inv_mix_byte(input logic [7:0] a0, input logic [7:0] a1,
                                              input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] p0, p1, p2, p3;
    p0 = xtime(xtime(xtime(a0))) ^ xtime(xtime(a0)) ^ xtime(a0);
    p1 = xtime(xtime(xtime(a1))) ^ xtime(a1) ^ a1;
    p2 = xtime(xtime(xtime(a2))) ^ xtime(xtime(a2)) ^ a2;
    p3 = xtime(xtime(xtime(a3))) ^ a3;
    return p0 ^ p1 ^ p2 ^ p3;
  endfunction

  logic [0:127] shifted;
  logic [0:127] subbed;
  logic [0:127] keyed;
  logic [0:127] mixed;
  logic [0:127] round_q;
  logic         valid_q;

  // Byte k sits at row k%4, column k/4; row r rotates right by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[8*(4*c+r) +: 8] = bus.state[8*(4*((c-r+4)%4)+r) +: 8];
      assign subbed[8*(4*c+r) +: 8]  = INV_SBOX[shifted[8*(4*c+r) +: 8]];
      assign mixed[8*(4*c+r) +: 8]   = inv_mix_byte(keyed[8*(4*c+r) +: 8],
                                                    keyed[8*(4*c+(r+1)%4) +: 8],
                                                    keyed[8*(4*c+(r+2)%4) +: 8],
                                                    keyed[8*(4*c+(r+3)%4) +: 8]);
    end
  end

  assign keyed = subbed ^ bus.key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.valid_in;
      if (bus.valid_in) round_q <= bus.last_round ? keyed : mixed;
    end
  end

  assign bus.round_out = round_q;
  assign bus.valid_out = valid_q;

`ifdef INV_ROUND_TRACE_EN
  always @(posedge clk) begin
    if (bus.valid_in)
      $display("inv_round: state=%h key=%h isr=%h isb=%h ark=%h imc=%h last=%0b",
               bus.state, bus.key, shifted, subbed, keyed, mixed, bus.last_round);
  end
`endif

endmodule

// File: tb/tb_inv_cipher_round_unit.sv
// Bench for inv_cipher_round_unit: directed vectors plus random beats checked against
// a byte-matrix reference model whose inverse S-box is derived from GF(2^8) arithmetic.
module tb_inv_cipher_round_unit;

  logic clk;
  logic rst;
  inv_cipher_round_unit_if bus ();

  inv_cipher_round_unit dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [127:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [127:0] last_exp = '0;

  // ---------------- reference model ----------------
  logic [7:0] inv_sbox_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_sbox_m[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [0:127] st, input logic [0:127] k,
                                         input logic lr);
    logic [7:0] m [4][4];
    logic [7:0] t [4][4];
    logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [0:127] res;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = st[8*(4*c+r) +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = inv_sbox_m[m[r][(c - r + 4) % 4]] ^ k[8*(4*c+r) +: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (lr) m[r][c] = t[r][c];
        else begin
          m[r][c] = 8'h00;
          for (int j = 0; j < 4; j++) m[r][c] ^= gmul(coef[(j - r + 4) % 4], t[j][c]);
        end
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[8*(4*c+r) +: 8] = m[r][c];
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_vec(input logic [0:127] st, input logic [0:127] k, input logic lr,
                           input logic [127:0] exp);
    @(negedge clk);
    bus.valid_in   = 1'b1;
    bus.last_round = lr;
    bus.state      = st;
    bus.key        = k;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 1);
  endtask

  task automatic drive_rand();
    logic [0:127] st, k;
    logic lr;
    st = {$urandom, $urandom, $urandom, $urandom};
    k  = {$urandom, $urandom, $urandom, $urandom};
    lr = 1'($urandom_range(0, 3) == 0);
    drive_vec(st, k, lr, model(st, k, lr));
  endtask

  task automatic drive_idle();
    @(negedge clk);
    bus.valid_in   = 1'b0;
    bus.last_round = 1'($urandom_range(0, 1));
    bus.state      = {$urandom, $urandom, $urandom, $urandom};
    bus.key        = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (exp_q.size() != 0 && exp_cyc_q[0] == cyc) begin
        check("valid_out_on_beat", 128'(bus.valid_out), 128'd1);
        check("round_out", bus.round_out, exp_q[0]);
        last_exp = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
      end else begin
        check("valid_out_idle", 128'(bus.valid_out), 128'd0);
        check("round_out_hold", bus.round_out, last_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.valid_in   = 1'b0;
    bus.last_round = 1'b0;
    bus.state      = '0;
    bus.key        = '0;
    rst = 1'b1;
    build_sbox();
    #1;
    check("reset_round_out", bus.round_out, 128'h0);
    check("reset_valid_out", 128'(bus.valid_out), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    drive_vec({16{8'h63}}, '0, 1'b0, 128'h0);
    drive_vec({16{8'h63}}, '0, 1'b1, 128'h0);
    drive_vec('0, '0, 1'b0, {16{8'h52}});
    drive_vec({16{8'h63}}, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0,
              128'hdb135345_f20a225c_01010101_c6c6c6c6);
    drive_vec({8'h63, 8'h00, {14{8'h63}}}, '0, 1'b1,
              128'h00000000_00520000_00000000_00000000);
    drive_idle();
    drive_idle();

    // four back-to-back random beats then idle
    for (int i = 0; i < 4; i++) drive_rand();
    for (int i = 0; i < 3; i++) drive_idle();

    // reset in the middle of a stream; the beat presented during reset is lost
    drive_rand();
    @(posedge clk);
    #3;
    bus.valid_in = 1'b1;
    bus.state    = {$urandom, $urandom, $urandom, $urandom};
    rst = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    last_exp = '0;
    #1;
    check("midreset_round_out", bus.round_out, 128'h0);
    check("midreset_valid_out", 128'(bus.valid_out), 128'd0);
    @(negedge clk);
    @(posedge clk);
    #3;
    // release at the same negedge where the next beat is presented
    fork
      drive_rand();
      begin @(negedge clk); rst = 1'b0; end
    join
    drive_rand();
    drive_idle();

    // random traffic with gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7) drive_rand();
      else drive_idle();
    end
    for (int i = 0; i < 4; i++) drive_idle();
    @(negedge clk);
    check("pending_results", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
